sign_ext_arbiter: RTL and testbench

Shares one combinational sign-extension unit (IN_W to OUT_W bits) among NUM_REQ requesters, e.g. decode, branch-offset and load/store immediate paths.
- Grants requesters round-robin and drives the shared unit's input from a stable register.
- Captures the extended result and returns it with the requester ID over a valid/ready response channel.
- Sits between the immediate-producing stages and the externally instantiated sign-extension module.

---
 rtl/sign_ext_pkg.sv | 49 ++++
 rtl/sign_ext_arbiter_rr_pick.sv | 45 ++++
 rtl/sign_ext_arbiter.sv | 137 +++++++++++++
 tb/tb_sign_ext_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sign_ext_pkg.sv
// Shared definitions for the sign-extension arbiter and its round-robin picker.
//   state_e   : arbiter FSM states (2-bit encoding, 2'b11 unused)
//   SE_IN_W   : default immediate width fed to the shared sign-extension unit
//   SE_OUT_W  : default extended result width
//   next_rr() : round-robin search returning {found, winner index}
package sign_ext_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int SE_IN_W  = 3;
  localparam int SE_OUT_W = 8;

  // The search helper works on a fixed maximum width; callers zero-pad.
  localparam int RR_MAX_REQ  = 8;
  localparam int RR_MAX_ID_W = 3;

  typedef struct packed {
    logic                   found;
    logic [RR_MAX_ID_W-1:0] idx;
  } rr_result_t;

  // First requester found searching ptr+1, ptr+2, ... modulo num_req.
  // Iterating from the farthest candidate down to the nearest lets the
  // nearest hit overwrite the others, so no early exit is needed.
  function automatic rr_result_t next_rr(input logic [RR_MAX_ID_W-1:0] ptr,
                                         input logic [RR_MAX_REQ-1:0]  req,
                                         input int                     num_req);
    rr_result_t             res;
    int                     cand;
    logic [RR_MAX_ID_W-1:0] cand_idx;
    res = '0;
    for (int k = RR_MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        cand     = (int'(ptr) + k) % num_req;
        cand_idx = cand[RR_MAX_ID_W-1:0];
        if (req[cand_idx]) begin
          res.found = 1'b1;
          res.idx   = cand_idx;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sign_ext_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, reusable by any shared-resource
// arbiter. The requester after ptr has highest priority, ptr itself lowest.
//   req     in   NUM_REQ  request levels
//   ptr     in   ID_W     index of the last-served requester
//   gnt_vec out  NUM_REQ  one-hot winner (all zero when nothing requests)
//   winner  out  ID_W     winner index (only meaningful when any=1)
//   any     out  1        at least one request is present
module rr_pick
  import sign_ext_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_vec,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [RR_MAX_REQ-1:0]  req_pad;
  logic [RR_MAX_ID_W-1:0] ptr_pad;
  rr_result_t             res;

  // NOTE: every variable written in a combinational block gets a default
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req;
    ptr_pad              = '0;
    ptr_pad[ID_W-1:0]    = ptr;
  end

  assign res    = next_rr(ptr_pad, req_pad, NUM_REQ);
  assign any    = res.found;
  assign winner = res.idx[ID_W-1:0];

  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_vec[i] = res.found && (res.idx == RR_MAX_ID_W'(i));
    end
  end

endmodule

// File: rtl/sign_ext_arbiter.sv
// sign_ext_arbiter: shares one external combinational sign-extension unit
// among NUM_REQ requesters. A winner's immediate is latched into ext_in, the
// unit settles for one full cycle (EXT), the result is captured and returned
// with the requester ID over a valid/ready response channel (RESP).
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request level (not sticky)
//   req_data   : immediate of requester i at [i*IN_W +: IN_W]
//   gnt        : one-hot acceptance, combinational, one cycle wide
//   ext_in     : registered input to the shared sign-extension unit
//   ext_out    : result from the shared sign-extension unit
//   rsp_valid / rsp_id / rsp_data / rsp_ready : response channel
module sign_ext_arbiter
  import sign_ext_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = SE_IN_W,
  parameter int OUT_W   = SE_OUT_W,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [IN_W-1:0]         ext_in,
  input  logic [OUT_W-1:0]        ext_out,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [OUT_W-1:0]        rsp_data,
  input  logic                    rsp_ready
);

  if (OUT_W <= IN_W) begin : g_bad_width
    $error("sign_ext_arbiter: OUT_W must be greater than IN_W");
  end
  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("sign_ext_arbiter: ID_W must equal clog2(NUM_REQ)");
  end
  if (NUM_REQ < 2 || NUM_REQ > RR_MAX_REQ) begin : g_bad_num_req
    $error("sign_ext_arbiter: NUM_REQ must be in 2..8");
  end

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [IN_W-1:0]     ext_in_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [OUT_W-1:0]    rsp_data_q;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_winner;
  logic                pick_any;
  logic [IN_W-1:0]     win_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_vec (pick_gnt),
    .winner  (pick_winner),
    .any     (pick_any)
  );

  // Immediate slice of the current winner.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_winner == ID_W'(i)) win_data = req_data[i*IN_W +: IN_W];
    end
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = pick_any ? EXT : IDLE;
      EXT:     state_d = RESP;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Grants are offered only in IDLE, and never while reset is asserted.
  always_comb begin
    gnt = '0;
    if (rst_n && state_q == IDLE) gnt = pick_gnt;
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      ext_in_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            ext_in_q <= win_data;
            id_q     <= pick_winner;
          end
        end
        EXT: begin
          rsp_data_q  <= ext_out;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= rsp_id_q;
          end
        end
        default: rsp_valid_q <= 1'b0;
      endcase
    end
  end

  assign ext_in    = ext_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sign_ext_arbiter.sv
// Self-checking bench for sign_ext_arbiter. Stimulus pushes expected grants
// and responses into queues; two monitors pop and compare on the falling
// edge whenever the DUT presents a grant or completes a response handshake.
module tb_sign_ext_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IN_W    = 3;
  localparam int OUT_W   = 8;
  localparam int ID_W    = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*IN_W-1:0] req_data;
  logic [NUM_REQ-1:0]      gnt;
  logic [IN_W-1:0]         ext_in;
  logic [OUT_W-1:0]        ext_out;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [OUT_W-1:0]        rsp_data;
  logic                    rsp_ready;

  sign_ext_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .ext_in    (ext_in),
    .ext_out   (ext_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  // External shared sign-extension unit.
  assign ext_out = {{(OUT_W-IN_W){ext_in[IN_W-1]}}, ext_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [OUT_W-1:0] data;
  } rsp_t;

  rsp_t exp_rsp[$];
  int   exp_gnt[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   last_gnt_cycle = -1;
  bit   spacing_en = 1'b0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Grant monitor: gnt seen at the falling edge is taken at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && gnt != '0) begin
      int g;
      check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      if (exp_gnt.size() == 0) begin
        check("gnt_unexpected", 32'(gnt), 32'd0);
      end else begin
        g = exp_gnt.pop_front();
        check("gnt_order", 32'(gnt), 32'(1 << g));
      end
      if (spacing_en && last_gnt_cycle >= 0) check("gnt_spacing", 32'(cycle - last_gnt_cycle), 32'd3);
      last_gnt_cycle = cycle;
    end
  end

  // Response monitor: a handshake visible at the falling edge completes next edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_t e;
      if (exp_rsp.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_rsp.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int id, input logic [IN_W-1:0] d);
    req_data[id*IN_W +: IN_W] = d;
  endtask

  task automatic push_exp(input int id, input logic [OUT_W-1:0] d);
    rsp_t e;
    e.id   = ID_W'(id);
    e.data = d;
    exp_gnt.push_back(id);
    exp_rsp.push_back(e);
  endtask

  task automatic wait_gnt(input int id, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt[id]) return;
    end
    check("wait_gnt_timeout", 32'(gnt[id]), 32'd1);
  endtask

  task automatic wait_rsp_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    check("wait_rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (exp_rsp.size() == 0 && !rsp_valid) return;
    end
    check("drain_timeout", 32'(exp_rsp.size()), 32'd0);
  endtask

  task automatic wait_gnt_queue_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (exp_gnt.size() == 0) return;
    end
    check("gnt_queue_timeout", 32'(exp_gnt.size()), 32'd0);
  endtask

  task automatic serve_one(input int id, input logic [IN_W-1:0] d, input logic [OUT_W-1:0] e);
    set_data(id, d);
    req = NUM_REQ'(1 << id);
    push_exp(id, e);
    wait_gnt(id, 20);
    step();
    req = '0;
    drain(30);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    rsp_ready = 1'b0;
    exp_rsp.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // ---- reset state (requests high must not leak a grant)
    rst_n     = 1'b0;
    req       = '1;
    req_data  = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_ext_in", 32'(ext_in), 32'd0);
    req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req_gnt", 32'(gnt), 32'd0);

    // ---- 1: single request, latency and captured value
    step();
    set_data(0, 3'b011);
    req = 4'b0001;
    push_exp(0, 8'h03);
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'h1);
    step();
    req = '0;
    @(negedge clk);
    check("t1_gnt_one_cycle", 32'(gnt), 32'd0);
    check("t1_ext_in", 32'(ext_in), 32'h3);
    check("t1_rsp_valid_n1", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    check("t1_rsp_valid_n2", 32'(rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(rsp_id), 32'd0);
    check("t1_rsp_data", 32'(rsp_data), 32'h03);
    step();
    rsp_ready = 1'b1;
    drain(20);

    // ---- 2: negative and all-ones immediates
    serve_one(2, 3'b100, 8'hFC);
    serve_one(1, 3'b111, 8'hFF);

    // ---- 3: all requesting, fresh reset, round-robin order and spacing
    do_reset();
    set_data(0, 3'b001);
    set_data(1, 3'b010);
    set_data(2, 3'b101);
    set_data(3, 3'b110);
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 8'h01);
      push_exp(1, 8'h02);
      push_exp(2, 8'hFD);
      push_exp(3, 8'hFE);
    end
    last_gnt_cycle = -1;
    spacing_en     = 1'b1;
    rsp_ready      = 1'b1;
    req            = 4'b1111;
    wait_gnt_queue_empty(60);
    req        = '0;
    spacing_en = 1'b0;
    drain(30);

    // ---- 4: stalled response, held stable, no grants while stalled
    rsp_ready = 1'b0;
    set_data(1, 3'b011);
    set_data(2, 3'b100);
    push_exp(1, 8'h03);
    push_exp(2, 8'hFC);
    req = 4'b0110;
    wait_rsp_valid(20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_id", 32'(rsp_id), 32'd1);
      check("t4_hold_data", 32'(rsp_data), 32'h03);
      check("t4_hold_gnt", 32'(gnt), 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    wait_gnt_queue_empty(30);
    req = '0;
    drain(30);

    // ---- 5: reset during EXT discards requester 3, pointer restarts at 0
    set_data(3, 3'b101);
    req = 4'b1000;
    exp_gnt.push_back(3);
    wait_gnt(3, 20);
    step();
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_rst_rsp_data", 32'(rsp_data), 32'd0);
    check("t5_rst_ext_in", 32'(ext_in), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_data(0, 3'b010);
    req = 4'b1001;
    push_exp(0, 8'h02);
    wait_gnt(0, 20);
    step();
    req = '0;
    drain(30);

    // ---- 6: request pulsed only during RESP is not served
    rsp_ready = 1'b0;
    set_data(2, 3'b011);
    req = 4'b0100;
    push_exp(2, 8'h03);
    wait_gnt(2, 20);
    step();
    req = '0;
    wait_rsp_valid(20);
    step();
    req = 4'b0001;
    @(negedge clk);
    check("t6_gnt_in_resp", 32'(gnt), 32'd0);
    step();
    req       = '0;
    rsp_ready = 1'b1;
    drain(20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_idle_gnt", 32'(gnt), 32'd0);
      check("t6_idle_valid", 32'(rsp_valid), 32'd0);
    end

    check("end_gnt_queue", 32'(exp_gnt.size()), 32'd0);
    check("end_rsp_queue", 32'(exp_rsp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
